// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, word-wide memory between the instruction-fetch
// requester (i_*) and the load/store requester (d_*). Only one memory
// transaction is in flight at a time. Each transaction is a request/done
// handshake, and the wait for memory is bounded by TIMEOUT_CYCLES.
// Data accesses that are not word aligned are rejected without touching
// memory.
//
// Parameters
//   TIMEOUT_CYCLES : max ACCESS cycles waiting for mem_ready (1..65535)
//
// Build option
//   MEM_ARB_RR_EN  : when defined, simultaneous requests are granted
//                    round-robin. When undefined, data has fixed priority
//                    over fetch.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   i_req, i_addr           : fetch request and address (held until i_done)
//   i_done                  : one-cycle completion pulse to fetch
//   d_req, d_we, d_addr,
//   d_wdata                 : load/store request (held until d_done)
//   d_done                  : one-cycle completion pulse to load/store
//   rdata, err              : read data / failure flag, valid with a done pulse
//   busy                    : high while in ACCESS or RESP
//   mem_req, mem_we,
//   mem_addr, mem_wdata     : memory request side (all registered)
//   mem_ready, mem_rdata    : memory completion and read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic        owner_data;   // 1 = current transaction belongs to load/store
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;
  logic        grant_data;
  logic        d_misaligned;
  logic [31:0] fetch_word;
  logic [31:0] data_word;

`ifdef MEM_ARB_RR_EN
  logic last_data;           // 1 = last grant went to load/store
`endif

  // Fetch never faults: its low address bits are simply discarded.
  assign fetch_word   = i_addr & 32'hFFFF_FFFC;
  assign data_word    = d_addr & 32'hFFFF_FFFC;
  assign d_misaligned = (d_addr[1:0] != 2'b00);
  assign wait_next    = wait_cnt + 16'd1;

  always_comb begin
    grant_data = d_req;
`ifdef MEM_ARB_RR_EN
    // On contention the port that was not granted last time wins.
    if (i_req && d_req) begin
      grant_data = ~last_data;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      wait_cnt   <= 16'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      rdata      <= 32'd0;
      err        <= 1'b0;
      busy       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_data  <= 1'b0;
`endif
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;

      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_data <= grant_data;
            wait_cnt   <= 16'd0;
            busy       <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_data  <= grant_data;
`endif
            if (grant_data && d_misaligned) begin
              // Rejected up front: memory is never strobed.
              state  <= RESP;
              d_done <= 1'b1;
              err    <= 1'b1;
              rdata  <= 32'd0;
            end else begin
              state   <= ACCESS;
              mem_req <= 1'b1;
              if (grant_data) begin
                mem_we    <= d_we;
                mem_addr  <= data_word;
                mem_wdata <= d_wdata;
              end else begin
                mem_we   <= 1'b0;
                mem_addr <= fetch_word;
              end
            end
          end
        end

        ACCESS: begin
          wait_cnt <= wait_next;
          // mem_ready is checked first so a completion on the last
          // allowed cycle beats the timeout.
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            err     <= 1'b0;
            rdata   <= mem_we ? 32'd0 : mem_rdata;
            i_done  <= ~owner_data;
            d_done  <= owner_data;
          end else if (wait_next == TIMEOUT_LIMIT) begin
            state   <= RESP;
            mem_req <= 1'b0;
            err     <= 1'b1;
            rdata   <= 32'd0;
            i_done  <= ~owner_data;
            d_done  <= owner_data;
          end
        end

        RESP: begin
          // Requests are deliberately ignored here so a requester can drop
          // req in its done cycle without starting a spurious access.
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Each transaction's expected timeline
// (winner, done cycle, err, rdata, memory strobes) is derived from the
// handshake rules with simple arithmetic and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_data = 1'b0;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge in an IDLE cycle; returns at the falling edge
  // of the IDLE cycle that follows the done pulse.
  task automatic txn(input bit ireq, input logic [31:0] iaddr,
                     input bit dreq, input bit dwe, input logic [31:0] daddr,
                     input logic [31:0] dwdata, input int delay,
                     input logic [31:0] mdata, input bit scramble);
    bit          win_d, mis, tmo, wr;
    int          done_c;
    logic [31:0] exp_addr, exp_rd;

    i_req = ireq; i_addr = iaddr;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
    mem_ready = 1'b0;
    chk1("idle_busy", busy, 1'b0);

`ifdef MEM_ARB_RR_EN
    win_d = (ireq && dreq) ? !last_data : dreq;
`else
    win_d = dreq;
`endif
    last_data = win_d;
    mis      = win_d && (daddr[1:0] != 2'b00);
    tmo      = !mis && (delay + 1 > T);
    wr       = win_d && dwe;
    done_c   = mis ? 1 : (tmo ? T + 1 : delay + 2);
    exp_addr = win_d ? {daddr[31:2], 2'b00} : {iaddr[31:2], 2'b00};
    exp_rd   = (mis || tmo || wr) ? 32'd0 : mdata;

    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (c < done_c) begin
        chk1("mem_req_access", mem_req, 1'b1);
        chk32("mem_addr", mem_addr, exp_addr);
        chk1("mem_we", mem_we, wr);
        if (wr) chk32("mem_wdata", mem_wdata, dwdata);
        chk1("busy_access", busy, 1'b1);
        chk1("done_early", i_done | d_done, 1'b0);
        mem_ready = (c == delay + 1);
        mem_rdata = mem_ready ? mdata : $urandom;
        if (scramble) begin
          if (win_d) d_addr = $urandom;
          else       i_addr = $urandom;
        end
      end else if (c == done_c) begin
        mem_ready = 1'b0;
        chk1("mem_req_resp", mem_req, 1'b0);
        chk1("i_done", i_done, !win_d);
        chk1("d_done", d_done, win_d);
        chk1("err", err, mis || tmo);
        chk32("rdata", rdata, exp_rd);
        chk1("busy_resp", busy, 1'b1);
        if (win_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end else begin
        chk1("busy_after", busy, 1'b0);
        chk1("done_after", i_done | d_done, 1'b0);
        chk1("mem_req_after", mem_req, 1'b0);
      end
    end
    $display("txn win=%s addr=%h we=%0d delay=%0d err=%0d rdata=%h",
             win_d ? "data" : "fetch", exp_addr, wr, delay, mis || tmo, rdata);
  endtask

  initial begin
    int          kind, dly;
    logic [31:0] a, w, m;
    bit          we;

    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_mem_wdata", mem_wdata, 32'd0);
    chk1("rst_i_done", i_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk32("rst_rdata", rdata, 32'd0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Fetch, ready in first ACCESS cycle.
    txn(1, 32'h104, 0, 0, 32'h0, 32'h0, 0, 32'h0050_0093, 0);
    // Fetch with low bits set: forced aligned, no fault.
    txn(1, 32'h10B, 0, 0, 32'h0, 32'h0, 1, 32'h1234_5678, 0);
    // SW with 3 wait cycles (completes on the last allowed cycle).
    txn(0, 32'h0, 1, 1, 32'h200, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 0);
    // LW, aligned.
    txn(0, 32'h0, 1, 0, 32'h300, 32'h0, 2, 32'hCAFE_F00D, 0);
    // Misaligned LW.
    txn(0, 32'h0, 1, 0, 32'h202, 32'h0, 0, 32'h0, 0);
    // Timeout: memory never ready.
    txn(0, 32'h0, 1, 0, 32'h400, 32'h0, 100, 32'h0, 0);
    txn(1, 32'h500, 0, 0, 32'h0, 32'h0, 100, 32'h0, 0);
    // Both requesting continuously.
    for (int k = 0; k < 4; k++)
      txn(1, 32'h600 + 32'(k * 4), 1, 0, 32'h700 + 32'(k * 4), 32'h0, 0, 32'hA000_0000 + 32'(k), 0);

    // Reset in the second ACCESS cycle.
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    chk1("pre_rst_mem_req", mem_req, 1'b1);
    reset = 1'b1; d_req = 1'b0;
    @(posedge clock); @(negedge clock);
    chk1("midrst_mem_req", mem_req, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", i_done | d_done, 1'b0);
    reset = 1'b0;
    last_data = 1'b0;
    @(posedge clock); @(negedge clock);
    chk1("postrst_done", i_done | d_done, 1'b0);
    $display("reset mid-access mem_req=%0d busy=%0d", mem_req, busy);
    txn(0, 32'h0, 1, 0, 32'h804, 32'h0, 1, 32'h5A5A_5A5A, 0);

    // Randomized mix.
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 2));
      dly  = int'($urandom_range(0, 5));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w    = $urandom;
      m    = $urandom;
      we   = 1'($urandom_range(0, 1));
      txn(kind != 1, $urandom, kind != 0, we, a, w, dly, m, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
